load_store_unit: RTL and testbench

LOAD_STORE_UNIT -- requirements
Module: load_store_unit

---
 rtl/lsu_pkg.sv | 26 ++
 rtl/load_store_unit_if.sv | 13 +
 rtl/load_store_unit_extend.sv | 20 ++
 rtl/load_store_unit.sv | 146 ++++++++++++++
 tb/tb_load_store_unit.sv | 261 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/lsu_pkg.sv
// Shared types for the load/store unit: FSM states, access-size codes and
// the byte-count helper.
package lsu_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RD,
    ST_RD_WAIT,
    ST_WR,
    ST_DONE
  } state_e;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;
  localparam logic [1:0] SZ_ILL  = 2'b11;

  function automatic logic [2:0] size_bytes(input logic [1:0] sz);
    case (sz)
      SZ_BYTE: return 3'd1;
      SZ_HALF: return 3'd2;
      default: return 3'd4;
    endcase
  endfunction

endpackage

// File: rtl/load_store_unit_if.sv
// Byte-wide data-memory bus between the load/store unit and its memory.
interface load_store_unit_if #(
  parameter int ADDR_W = 32
);
  logic [ADDR_W-1:0] addr;
  logic [7:0]        wdata;
  logic [7:0]        rdata;
  logic              read;
  logic              write;

  modport master (output addr, wdata, read, write, input rdata);
  modport slave  (input addr, wdata, read, write, output rdata);
endinterface

// File: rtl/load_store_unit_extend.sv
// Sign/zero extension of an assembled little-endian load to 32 bits.
module lsu_extend
  import lsu_pkg::*;
(
  input  logic [31:0] bytes_i,
  input  logic [1:0]  size_i,
  input  logic        unsigned_i,
  output logic [31:0] ext_o
);

  always_comb begin
    ext_o = bytes_i;
    case (size_i)
      SZ_BYTE: ext_o = {{24{~unsigned_i & bytes_i[7]}}, bytes_i[7:0]};
      SZ_HALF: ext_o = {{16{~unsigned_i & bytes_i[15]}}, bytes_i[15:0]};
      default: ext_o = bytes_i;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// Sequences byte/half/word loads and stores onto a byte-wide memory, one byte
// per cycle, with alignment/size checking and sign/zero-extended load results.
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int ADDR_W = 32
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              req_i,
  input  logic              we_i,
  input  logic [1:0]        size_i,
  input  logic              unsigned_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [31:0]       wdata_i,
  output logic              busy_o,
  output logic              done_o,
  output logic              err_o,
  output logic [31:0]       rdata_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [7:0]        mem_data_o,
  output logic              mem_read_o,
  output logic              mem_write_o,
  input  logic [7:0]        mem_data_i
);

  state_e            state_q, state_d;
  logic [2:0]        cnt_q, cnt_d;
  logic [1:0]        size_q, size_d;
  logic              uns_q, uns_d;
  logic [ADDR_W-1:0] base_q, base_d;
  logic [31:0]       wdata_q, wdata_d;
  logic              err_q, err_d;
  logic [31:0]       asm_q, asm_d;
  logic [31:0]       rdata_q, rdata_d;

  logic              accept;
  logic              bad_req;
  logic [2:0]        n_bytes;
  logic              last;
  logic [1:0]        lane;
  logic [31:0]       ext_w;

  assign accept  = (state_q == ST_IDLE) && req_i;
  assign bad_req = (size_i == SZ_ILL) ||
                   ((size_i == SZ_HALF) && addr_i[0]) ||
                   ((size_i == SZ_WORD) && (addr_i[1:0] != 2'b00));
  assign n_bytes = size_bytes(size_q);
  assign last    = (cnt_q == n_bytes - 3'd1);
  // Memory data lags the read strobe by one cycle, so it lands in lane cnt-1.
  assign lane    = cnt_q[1:0] - 2'd1;

  always_comb begin
    asm_d = asm_q;
    if (accept) begin
      asm_d = '0;
    end else if (((state_q == ST_RD) && (cnt_q != 3'd0)) || (state_q == ST_RD_WAIT)) begin
      asm_d[{lane, 3'b000} +: 8] = mem_data_i;
    end
  end

  lsu_extend u_extend (
    .bytes_i    (asm_d),
    .size_i     (size_q),
    .unsigned_i (uns_q),
    .ext_o      (ext_w)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    size_d  = size_q;
    uns_d   = uns_q;
    base_d  = base_q;
    wdata_d = wdata_q;
    err_d   = err_q;
    rdata_d = rdata_q;
    case (state_q)
      ST_IDLE: begin
        if (req_i) begin
          size_d  = size_i;
          uns_d   = unsigned_i;
          base_d  = addr_i;
          wdata_d = wdata_i;
          err_d   = bad_req;
          cnt_d   = 3'd0;
          if (bad_req)   state_d = ST_DONE;
          else if (we_i) state_d = ST_WR;
          else           state_d = ST_RD;
        end
      end
      ST_RD: begin
        cnt_d = cnt_q + 3'd1;
        if (last) state_d = ST_RD_WAIT;
      end
      ST_RD_WAIT: begin
        rdata_d = ext_w;
        state_d = ST_DONE;
      end
      ST_WR: begin
        cnt_d = cnt_q + 3'd1;
        if (last) state_d = ST_DONE;
      end
      ST_DONE: begin
        cnt_d   = 3'd0;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      size_q  <= '0;
      uns_q   <= 1'b0;
      base_q  <= '0;
      wdata_q <= '0;
      err_q   <= 1'b0;
      asm_q   <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      size_q  <= size_d;
      uns_q   <= uns_d;
      base_q  <= base_d;
      wdata_q <= wdata_d;
      err_q   <= err_d;
      asm_q   <= asm_d;
      rdata_q <= rdata_d;
    end
  end

  // Strobes and bus fields decode from state so reset silences them at once.
  assign busy_o      = (state_q != ST_IDLE);
  assign done_o      = (state_q == ST_DONE);
  assign err_o       = (state_q == ST_DONE) && err_q;
  assign rdata_o     = rdata_q;
  assign mem_read_o  = (state_q == ST_RD);
  assign mem_write_o = (state_q == ST_WR);
  assign mem_addr_o  = (mem_read_o || mem_write_o) ? base_q + ADDR_W'(cnt_q) : '0;
  assign mem_data_o  = mem_write_o ? 8'(wdata_q >> {cnt_q[1:0], 3'b000}) : 8'h00;

endmodule

// File: tb/tb_load_store_unit.sv
// Bench for load_store_unit: directed vector table, hand-written corner
// sequences and randomized accesses against a byte-array reference model.
module tb_load_store_unit;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        req_i, we_i, unsigned_i;
  logic [1:0]  size_i;
  logic [31:0] addr_i, wdata_i;
  logic        busy_o, done_o, err_o;
  logic [31:0] rdata_o;
  logic        preload;

  load_store_unit_if #(.ADDR_W(32)) mif ();

  load_store_unit #(.ADDR_W(32)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .req_i(req_i), .we_i(we_i), .size_i(size_i),
    .unsigned_i(unsigned_i), .addr_i(addr_i), .wdata_i(wdata_i),
    .busy_o(busy_o), .done_o(done_o), .err_o(err_o), .rdata_o(rdata_o),
    .mem_addr_o(mif.addr), .mem_data_o(mif.wdata), .mem_read_o(mif.read),
    .mem_write_o(mif.write), .mem_data_i(mif.rdata)
  );

  always #5 clk_i = ~clk_i;

  function automatic logic [7:0] init_byte(input int a);
    case (a)
      5:  return 8'h80;
      16: return 8'h78;
      17: return 8'h56;
      18: return 8'h34;
      19: return 8'h12;
      default: return 8'(a * 7 + 3);
    endcase
  endfunction

  // Registered byte-wide memory
  logic [7:0] mem [0:255];
  logic [7:0] rd_q;
  assign mif.rdata = rd_q;
  always @(posedge clk_i) begin
    if (preload) begin
      for (int i = 0; i < 256; i++) mem[i] <= init_byte(i);
    end else if (mif.write) begin
      mem[mif.addr[7:0]] <= mif.wdata;
    end
    if (mif.read) rd_q <= mem[mif.addr[7:0]];
  end

  // Reference model state
  logic [7:0]  ref_mem [0:255];
  logic [31:0] ref_rd;

  int n_cmp = 0;
  int n_bad = 0;

  logic [31:0] rd_log, wr_log;
  logic [31:0] addr_log [0:31];
  logic [7:0]  data_log [0:31];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic do_op(input logic we, input logic [1:0] sz, input logic uns,
                       input logic [31:0] addr, input logic [31:0] wd,
                       output int lat, output logic err, output logic [31:0] rd);
    @(negedge clk_i);
    req_i = 1'b1; we_i = we; size_i = sz; unsigned_i = uns; addr_i = addr; wdata_i = wd;
    @(posedge clk_i);
    #1 req_i = 1'b0;
    lat = -1; err = 1'bx; rd = 'x;
    rd_log = '0; wr_log = '0;
    for (int c = 1; c <= 20; c++) begin
      @(negedge clk_i);
      rd_log[c]   = mif.read;
      wr_log[c]   = mif.write;
      addr_log[c] = mif.addr;
      data_log[c] = mif.wdata;
      if (done_o) begin
        lat = c; err = err_o; rd = rdata_o;
        break;
      end
    end
  endtask

  function automatic int nbytes(input logic [1:0] sz);
    return (sz == 2'b11) ? 4 : (1 << sz);
  endfunction

  function automatic logic is_err(input logic [1:0] sz, input logic [31:0] addr);
    return (sz == 2'b11) || ((addr % nbytes(sz)) != 0);
  endfunction

  // Strobe pattern implied by the access: N consecutive strobe cycles from 1.
  function automatic logic strobes_ok(input logic we, input logic [1:0] sz,
                                      input logic [31:0] base, input logic [31:0] wd);
    int n;
    logic [31:0] em;
    logic ok;
    n  = nbytes(sz);
    em = is_err(sz, base) ? 32'd0 : (((32'd1 << n) - 32'd1) << 1);
    ok = (rd_log == (we ? 32'd0 : em)) && (wr_log == (we ? em : 32'd0));
    if (em != 0) begin
      for (int k = 1; k <= n; k++) begin
        if (addr_log[k] != base + 32'(k - 1)) ok = 1'b0;
        if (we && data_log[k] != 8'(wd >> (8 * (k - 1)))) ok = 1'b0;
      end
    end
    return ok;
  endfunction

  function automatic logic [31:0] model_load(input logic [1:0] sz, input logic uns,
                                             input logic [31:0] addr);
    longint v = 0;
    int n = nbytes(sz);
    for (int i = 0; i < n; i++) v += longint'(ref_mem[8'(addr + 32'(i))]) << (8 * i);
    if (!uns && v >= (longint'(1) << (8 * n - 1))) v -= (longint'(1) << (8 * n));
    return 32'(v);
  endfunction

  task automatic model_store(input logic [1:0] sz, input logic [31:0] addr, input logic [31:0] wd);
    for (int i = 0; i < nbytes(sz); i++) ref_mem[8'(addr + 32'(i))] = 8'(wd >> (8 * i));
  endtask

  typedef struct {
    logic        we;
    logic [1:0]  sz;
    logic        uns;
    logic [31:0] addr;
    logic [31:0] wd;
    logic        exp_err;
    int          exp_lat;
    logic [31:0] exp_rd;
  } vec_t;

  vec_t vt [15];

  initial begin
    int lat;
    logic err;
    logic [31:0] rd;
    logic [6:1] bsy_v, wr_v, dn_v;
    logic [31:0] stray;

    vt[0]  = '{1'b0, 2'b10, 1'b0, 32'h10, 32'h0,        1'b0, 6, 32'h12345678};
    vt[1]  = '{1'b0, 2'b00, 1'b0, 32'h05, 32'h0,        1'b0, 3, 32'hFFFFFF80};
    vt[2]  = '{1'b0, 2'b00, 1'b1, 32'h05, 32'h0,        1'b0, 3, 32'h00000080};
    vt[3]  = '{1'b1, 2'b10, 1'b0, 32'h08, 32'hDEADBEEF, 1'b0, 5, 32'h00000080};
    vt[4]  = '{1'b0, 2'b10, 1'b0, 32'h08, 32'h0,        1'b0, 6, 32'hDEADBEEF};
    vt[5]  = '{1'b0, 2'b10, 1'b0, 32'h02, 32'h0,        1'b1, 1, 32'hDEADBEEF};
    vt[6]  = '{1'b0, 2'b11, 1'b0, 32'h00, 32'h0,        1'b1, 1, 32'hDEADBEEF};
    vt[7]  = '{1'b0, 2'b01, 1'b0, 32'h11, 32'h0,        1'b1, 1, 32'hDEADBEEF};
    vt[8]  = '{1'b0, 2'b01, 1'b0, 32'h12, 32'h0,        1'b0, 4, 32'h00001234};
    vt[9]  = '{1'b1, 2'b01, 1'b0, 32'h20, 32'hAAAA8001, 1'b0, 3, 32'h00001234};
    vt[10] = '{1'b0, 2'b01, 1'b0, 32'h20, 32'h0,        1'b0, 4, 32'hFFFF8001};
    vt[11] = '{1'b0, 2'b01, 1'b1, 32'h20, 32'h0,        1'b0, 4, 32'h00008001};
    vt[12] = '{1'b1, 2'b00, 1'b0, 32'h21, 32'h0000007F, 1'b0, 2, 32'h00008001};
    vt[13] = '{1'b0, 2'b00, 1'b0, 32'h21, 32'h0,        1'b0, 3, 32'h0000007F};
    vt[14] = '{1'b1, 2'b11, 1'b0, 32'h24, 32'h55555555, 1'b1, 1, 32'h0000007F};

    for (int i = 0; i < 256; i++) ref_mem[i] = init_byte(i);
    ref_rd = 32'h0;

    rst_i = 1'b1; preload = 1'b1;
    req_i = 1'b0; we_i = 1'b0; size_i = 2'b00; unsigned_i = 1'b0; addr_i = '0; wdata_i = '0;
    repeat (3) @(posedge clk_i);
    preload = 1'b0;
    @(negedge clk_i);
    check("reset busy_o",      32'(busy_o),    32'h0);
    check("reset done_o",      32'(done_o),    32'h0);
    check("reset err_o",       32'(err_o),     32'h0);
    check("reset rdata_o",     rdata_o,        32'h0);
    check("reset mem_addr_o",  mif.addr,       32'h0);
    check("reset mem_data_o",  32'(mif.wdata), 32'h0);
    check("reset mem_read_o",  32'(mif.read),  32'h0);
    check("reset mem_write_o", 32'(mif.write), 32'h0);
    rst_i = 1'b0;

    foreach (vt[i]) begin
      do_op(vt[i].we, vt[i].sz, vt[i].uns, vt[i].addr, vt[i].wd, lat, err, rd);
      check($sformatf("vec%0d latency", i), 32'(lat), 32'(vt[i].exp_lat));
      check($sformatf("vec%0d err_o", i),   32'(err), 32'(vt[i].exp_err));
      check($sformatf("vec%0d rdata_o", i), rd, vt[i].exp_rd);
      check($sformatf("vec%0d strobes", i),
            32'(strobes_ok(vt[i].we, vt[i].sz, vt[i].addr, vt[i].wd)), 32'h1);
      if (vt[i].we && !vt[i].exp_err) model_store(vt[i].sz, vt[i].addr, vt[i].wd);
    end
    ref_rd = 32'h0000007F;

    // req_i held high across a byte store: ignored while busy, re-accepted from IDLE
    @(negedge clk_i);
    req_i = 1'b1; we_i = 1'b1; size_i = 2'b00; unsigned_i = 1'b0; addr_i = 32'h30; wdata_i = 32'h11;
    for (int c = 1; c <= 6; c++) begin
      @(negedge clk_i);
      bsy_v[c] = busy_o; wr_v[c] = mif.write; dn_v[c] = done_o;
      if (c == 4) req_i = 1'b0;
    end
    check("held req busy pattern",  32'(bsy_v), 32'(6'b011011));
    check("held req write pattern", 32'(wr_v),  32'(6'b001001));
    check("held req done pattern",  32'(dn_v),  32'(6'b010010));
    model_store(2'b00, 32'h30, 32'h11);

    // Reset in cycle 3 of a word load
    @(negedge clk_i);
    req_i = 1'b1; we_i = 1'b0; size_i = 2'b10; unsigned_i = 1'b0; addr_i = 32'h10;
    @(posedge clk_i);
    #1 req_i = 1'b0;
    repeat (3) @(negedge clk_i);
    check("mid-read strobe before reset", 32'(mif.read), 32'h1);
    check("mid-read addr before reset",   mif.addr, 32'h12);
    rst_i = 1'b1;
    #1;
    check("reset mid-read mem_read_o", 32'(mif.read), 32'h0);
    check("reset mid-read busy_o",     32'(busy_o),   32'h0);
    check("reset mid-read mem_addr_o", mif.addr,      32'h0);
    check("reset mid-read rdata_o",    rdata_o,       32'h0);
    @(negedge clk_i);
    rst_i = 1'b0;
    stray = '0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk_i);
      stray = stray | 32'({mif.read, mif.write, busy_o, done_o});
    end
    check("no activity after reset", stray, 32'h0);
    do_op(1'b0, 2'b01, 1'b0, 32'h10, 32'h0, lat, err, rd);
    check("post-reset half latency", 32'(lat), 32'd4);
    check("post-reset half err_o",   32'(err), 32'h0);
    check("post-reset half rdata_o", rd, 32'h00005678);
    ref_rd = 32'h00005678;

    for (int t = 0; t < 60; t++) begin
      logic        we, uns, e;
      logic [1:0]  sz;
      logic [31:0] addr, wd;
      int          elat;
      we   = 1'($urandom_range(0, 1));
      uns  = 1'($urandom_range(0, 1));
      sz   = 2'($urandom_range(0, 3));
      addr = 32'($urandom_range(0, 63));
      wd   = $urandom;
      e    = is_err(sz, addr);
      elat = e ? 1 : (we ? nbytes(sz) + 1 : nbytes(sz) + 2);
      if (!e && !we) ref_rd = model_load(sz, uns, addr);
      do_op(we, sz, uns, addr, wd, lat, err, rd);
      check($sformatf("rand%0d latency", t), 32'(lat), 32'(elat));
      check($sformatf("rand%0d err_o", t),   32'(err), 32'(e));
      check($sformatf("rand%0d rdata_o", t), rd, ref_rd);
      check($sformatf("rand%0d strobes", t), 32'(strobes_ok(we, sz, addr, wd)), 32'h1);
      if (!e && we) model_store(sz, addr, wd);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
